pong_score_keeper: RTL and testbench

Scoring and serve-control stage downstream of the pong game core. It samples the ball X position on each game tick, detects misses at the left and right screen edges, and keeps per-player scores. A state machine holds play for a fixed number of ticks after each point, then issues a one-cycle `serve` pulse that restarts the ball in the core. It declares a winner when a score reaches `WIN_SCORE`.

---
 rtl/pong_score_keeper.sv | 134 +++++++++++++
 tb/tb_pong_score_keeper.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: edge-miss detection, per-player scoring and serve
// sequencing for the pong game core. Every output is registered; the
// state output is the FSM state register itself.
module pong_score_keeper #(
    parameter int SCREEN_WIDTH = 200,
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_TICKS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] ball_x,
    input  logic       score_clear,
    output logic       serve,
    output logic       point_left,
    output logic       point_right,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_HOLD  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] EDGE_X    = 8'(SCREEN_WIDTH - 1);
    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS - 1);

    state_t     cur_state, nxt_state;
    logic [7:0] hold_cnt, nxt_hold;
    logic [3:0] nxt_score_l, nxt_score_r;
    logic [3:0] inc_l, inc_r;
    logic       nxt_serve, nxt_pt_l, nxt_pt_r, nxt_over, nxt_winner;

    assign state = cur_state;
    assign inc_l = score_left + 4'd1;
    assign inc_r = score_right + 4'd1;

    // State and every output register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= S_SERVE;
            hold_cnt    <= 8'd0;
            serve       <= 1'b0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            hold_cnt    <= nxt_hold;
            serve       <= nxt_serve;
            point_left  <= nxt_pt_l;
            point_right <= nxt_pt_r;
            score_left  <= nxt_score_l;
            score_right <= nxt_score_r;
            game_over   <= nxt_over;
            winner      <= nxt_winner;
        end
    end

    // Next state and next output values; score_clear overrides tick handling.
    always_comb begin
        nxt_state   = cur_state;
        nxt_hold    = hold_cnt;
        nxt_serve   = 1'b0;
        nxt_pt_l    = 1'b0;
        nxt_pt_r    = 1'b0;
        nxt_score_l = score_left;
        nxt_score_r = score_right;
        nxt_over    = game_over;
        nxt_winner  = winner;

        if (score_clear) begin
            nxt_state   = S_SERVE;
            nxt_hold    = 8'd0;
            nxt_score_l = 4'd0;
            nxt_score_r = 4'd0;
            nxt_over    = 1'b0;
            nxt_winner  = 1'b0;
        end else begin
            case (cur_state)
                S_SERVE: begin
                    nxt_serve = 1'b1;
                    nxt_state = S_PLAY;
                end
                S_PLAY: begin
                    if (tick && ball_x == 8'd0) begin
                        // Left player missed: point to the right.
                        nxt_score_r = inc_r;
                        nxt_pt_r    = 1'b1;
                        if (inc_r == WIN_VAL) begin
                            nxt_state  = S_OVER;
                            nxt_over   = 1'b1;
                            nxt_winner = 1'b1;
                        end else begin
                            nxt_state = S_HOLD;
                            nxt_hold  = HOLD_LOAD;
                        end
                    end else if (tick && ball_x == EDGE_X) begin
                        // Right player missed: point to the left.
                        nxt_score_l = inc_l;
                        nxt_pt_l    = 1'b1;
                        if (inc_l == WIN_VAL) begin
                            nxt_state  = S_OVER;
                            nxt_over   = 1'b1;
                            nxt_winner = 1'b0;
                        end else begin
                            nxt_state = S_HOLD;
                            nxt_hold  = HOLD_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    // ball_x ignored here so a parked ball cannot rescore.
                    if (tick) begin
                        if (hold_cnt == 8'd0) nxt_state = S_SERVE;
                        else                  nxt_hold  = hold_cnt - 8'd1;
                    end
                end
                default: ;  // S_OVER: frozen until clear or reset
            endcase
        end
    end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with default parameters
// (width 200, win at 9, 16-tick hold).
module tb_pong_score_keeper;

    logic       clk = 1'b0;
    logic       reset, tick, score_clear;
    logic [7:0] ball_x;
    logic       serve, point_left, point_right, game_over, winner;
    logic [3:0] score_left, score_right;
    logic [1:0] state;

    int n_chk = 0;
    int n_err = 0;

    pong_score_keeper dut (
        .clk(clk), .reset(reset), .tick(tick), .ball_x(ball_x),
        .score_clear(score_clear), .serve(serve), .point_left(point_left),
        .point_right(point_right), .score_left(score_left),
        .score_right(score_right), .game_over(game_over), .winner(winner),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_at(input logic [7:0] x);
        tick   = 1'b1;
        ball_x = x;
        step();
        tick   = 1'b0;
    endtask

    // Score one point from PLAY and return to PLAY (point, 16 hold ticks, serve).
    task automatic score_point(input logic [7:0] x);
        tick_at(x);
        repeat (16) tick_at(x);
        step();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; score_clear = 1'b0; ball_x = 8'd100;
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_serve", serve, 0);
        chk("rst_sl", score_left, 0);
        chk("rst_sr", score_right, 0);
        chk("rst_over", game_over, 0);

        reset = 1'b0;
        step();
        chk("first_serve", serve, 1);
        chk("first_play", state, 1);
        step();
        chk("serve_once", serve, 0);

        // Edge position without tick, mid-field and one-short-of-edge ticks.
        ball_x = 8'd0;
        step();
        chk("notick_sr", score_right, 0);
        chk("notick_pr", point_right, 0);
        tick_at(8'd100);
        tick_at(8'd198);
        chk("mid_state", state, 1);
        chk("mid_sl", score_left, 0);

        // Left miss.
        tick_at(8'd0);
        chk("lmiss_sr", score_right, 1);
        chk("lmiss_pr", point_right, 1);
        chk("lmiss_state", state, 2);
        step();
        chk("lmiss_pr_off", point_right, 0);
        repeat (16) tick_at(8'd0);
        chk("hold1_serve_st", state, 0);
        chk("hold1_sr", score_right, 1);
        step();
        chk("hold1_serve", serve, 1);

        // Right miss, then 16 back-to-back ticks parked at the edge.
        tick_at(8'd199);
        chk("rmiss_sl", score_left, 1);
        chk("rmiss_pl", point_left, 1);
        chk("rmiss_state", state, 2);
        repeat (15) tick_at(8'd199);
        chk("hold_15", state, 2);
        chk("hold_sl", score_left, 1);
        chk("hold_pl", point_left, 0);
        tick_at(8'd199);
        chk("hold_16", state, 0);
        chk("hold_16_serve", serve, 0);
        step();
        chk("hold_serve", serve, 1);
        step();
        chk("hold_serve_off", serve, 0);
        chk("hold_sl2", score_left, 1);

        // Win: right reaches 9 (7 full rounds, then the winning point).
        repeat (7) score_point(8'd0);
        chk("pre_win_sr", score_right, 8);
        tick_at(8'd0);
        chk("win_sr", score_right, 9);
        chk("win_over", game_over, 1);
        chk("win_winner", winner, 1);
        chk("win_state", state, 3);
        chk("win_pr", point_right, 1);
        repeat (3) tick_at(8'd0);
        chk("over_sr", score_right, 9);
        chk("over_state", state, 3);
        chk("over_serve", serve, 0);

        // Clear from OVER.
        score_clear = 1'b1;
        step();
        score_clear = 1'b0;
        chk("clr_sr", score_right, 0);
        chk("clr_sl", score_left, 0);
        chk("clr_over", game_over, 0);
        chk("clr_state", state, 0);
        step();
        chk("clr_serve", serve, 1);

        // Clear beats a qualifying tick in PLAY.
        score_clear = 1'b1;
        tick_at(8'd0);
        score_clear = 1'b0;
        chk("clrp_sr", score_right, 0);
        chk("clrp_pr", point_right, 0);
        chk("clrp_state", state, 0);
        step();
        chk("clrp_serve", serve, 1);

        // Reset mid-hold at 3/2.
        score_point(8'd0);
        score_point(8'd0);
        score_point(8'd199);
        score_point(8'd199);
        tick_at(8'd199);
        chk("pre_rst_sl", score_left, 3);
        chk("pre_rst_sr", score_right, 2);
        chk("pre_rst_state", state, 2);
        tick_at(8'd50);
        reset = 1'b1;
        step();
        chk("mrst_state", state, 0);
        chk("mrst_sl", score_left, 0);
        chk("mrst_sr", score_right, 0);
        chk("mrst_serve", serve, 0);
        chk("mrst_pl", point_left, 0);
        reset = 1'b0;
        step();
        chk("mrst_rel_serve", serve, 1);
        chk("mrst_rel_state", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
